// File: rtl/ext_bus_region_slave.sv
// Multiplexed external-bus responder: multi-phase address collection, windowed decode,
// one-shot backend request/ack with a minimum wait and a timeout before EXT_READY.
module ext_bus_region_slave #(
  parameter int AD_W        = 16,
  parameter int ADDR_PHASES = 2,
  parameter int DATA_W      = 8,
  parameter int REGIONS     = 2,
  parameter logic [REGIONS*AD_W*ADDR_PHASES-1:0] REGION_BASE = {32'h00000000, 32'h1A100000},
  parameter logic [REGIONS*AD_W*ADDR_PHASES-1:0] REGION_MASK = {32'h00000000, 32'hFFFE0000},
  parameter logic [AD_W*ADDR_PHASES-1:0]         LOCAL_LIMIT = 32'h00001000,
  parameter int MIN_WAIT    = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ae,
  input  logic                          ext_read,
  input  logic                          ext_write,
  input  logic [AD_W-1:0]               ad_in,
  output logic [AD_W-1:0]               ad_out,
  output logic                          ad_oe,
  output logic                          ext_ready,
  output logic [REGIONS-1:0]            region_sel,
  output logic [AD_W*ADDR_PHASES-1:0]   mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_rd,
  output logic                          mem_wr,
  input  logic [DATA_W-1:0]             mem_rdata,
  input  logic                          mem_ack,
  output logic                          bus_err,
  output logic                          addr_err
);

  localparam int ADDR_W = AD_W*ADDR_PHASES;
  localparam int PH_W   = $clog2(ADDR_PHASES+1);
  localparam int CNT_W  = $clog2(TIMEOUT+1);
  localparam logic [PH_W-1:0]  PH_FULL = PH_W'(ADDR_PHASES);
  localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_WAIT);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ADDR, ARMED, REQ, WAIT, DONE} state_t;

  state_t              state;
  logic [PH_W-1:0]     phase_cnt;
  logic [ADDR_W-1:0]   addr_buf;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata_q;
  logic                is_wr;
  logic                ack_seen;

  logic [REGIONS-1:0]  hit_oh;
  logic                found;
  logic [CNT_W-1:0]    next_cnt;
  logic                ack_now;
  logic                strobe_on;

  // Lowest-index window wins; on-chip addresses are never claimed.
  always_comb begin
    hit_oh = '0;
    found  = 1'b0;
    for (int i = 0; i < REGIONS; i++) begin
      if (!found && ((addr_buf & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                     (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W]))) begin
        hit_oh[i] = 1'b1;
        found     = 1'b1;
      end
    end
    if (addr_buf < LOCAL_LIMIT) hit_oh = '0;
  end

  assign next_cnt  = cnt + CNT_W'(1);
  assign ack_now   = ack_seen | mem_ack;
  assign strobe_on = is_wr ? ext_write : ext_read;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      addr_buf   <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      is_wr      <= 1'b0;
      ack_seen   <= 1'b0;
      ad_out     <= '0;
      ad_oe      <= 1'b0;
      ext_ready  <= 1'b0;
      region_sel <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      bus_err    <= 1'b0;
      addr_err   <= 1'b0;
    end else begin
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      bus_err  <= 1'b0;
      addr_err <= 1'b0;
      if (ae) begin
        state <= ADDR;
        if (state != ADDR) begin
          // Fresh address (possibly aborting an access in flight).
          phase_cnt           <= PH_W'(1);
          addr_buf[AD_W-1:0]  <= ad_in;
          ext_ready           <= 1'b0;
          ad_oe               <= 1'b0;
          ad_out              <= '0;
          region_sel          <= '0;
          ack_seen            <= 1'b0;
        end else if (phase_cnt < PH_FULL) begin
          addr_buf[int'(phase_cnt)*AD_W +: AD_W] <= ad_in;
          phase_cnt <= phase_cnt + PH_W'(1);
        end
      end else begin
        case (state)
          ADDR: begin
            phase_cnt <= '0;
            if (phase_cnt == PH_FULL) begin
              mem_addr   <= addr_buf;
              region_sel <= hit_oh;
              state      <= (|hit_oh) ? ARMED : IDLE;
            end else begin
              addr_err <= 1'b1;
              state    <= IDLE;
            end
          end
          ARMED: begin
            if (ext_read && ext_write) begin
              bus_err    <= 1'b1;
              region_sel <= '0;
              state      <= IDLE;
            end else if (ext_write || ext_read) begin
              if (ext_write) mem_wdata <= ad_in[DATA_W-1:0];
              is_wr    <= ext_write;
              mem_wr   <= ext_write;
              mem_rd   <= ext_read;
              cnt      <= '0;
              ack_seen <= 1'b0;
              state    <= REQ;
            end
          end
          REQ, WAIT: begin
            // cnt is the cycle offset from the request cycle.
            state <= WAIT;
            cnt   <= next_cnt;
            if (mem_ack && !ack_seen) begin
              ack_seen <= 1'b1;
              if (!is_wr) rdata_q <= mem_rdata;
            end
            if (ack_now && next_cnt >= MIN_CNT) begin
              state     <= DONE;
              ext_ready <= 1'b1;
              ad_oe     <= !is_wr;
              ad_out    <= is_wr ? '0 : AD_W'(ack_seen ? rdata_q : mem_rdata);
            end else if (next_cnt >= TO_CNT) begin
              state     <= DONE;
              ext_ready <= 1'b1;
              bus_err   <= 1'b1;
              rdata_q   <= '1;
              ad_oe     <= !is_wr;
              ad_out    <= is_wr ? '0 : AD_W'({DATA_W{1'b1}});
            end
          end
          DONE: begin
            if (!strobe_on) begin
              ext_ready  <= 1'b0;
              ad_oe      <= 1'b0;
              ad_out     <= '0;
              region_sel <= '0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ext_bus_region_slave.sv
// Randomized transaction bench for ext_bus_region_slave against a transaction-level model.
module tb_ext_bus_region_slave;

  localparam int MIN_WAIT = 2;
  localparam int TIMEOUT  = 255;
  localparam logic [31:0] RBASE [2] = '{32'h1A100000, 32'h00000000};
  localparam logic [31:0] RMASK [2] = '{32'hFFFE0000, 32'h00000000};
  localparam logic [31:0] LIMIT = 32'h00001000;

  logic        clk = 1'b0;
  logic        rst;
  logic        ae, ext_read, ext_write, mem_ack;
  logic [15:0] ad_in, ad_out;
  logic        ad_oe, ext_ready, mem_rd, mem_wr, bus_err, addr_err;
  logic [1:0]  region_sel;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_errors = 0;

  ext_bus_region_slave #(
    .AD_W(16), .ADDR_PHASES(2), .DATA_W(8), .REGIONS(2),
    .REGION_BASE({RBASE[1], RBASE[0]}), .REGION_MASK({RMASK[1], RMASK[0]}),
    .LOCAL_LIMIT(LIMIT), .MIN_WAIT(MIN_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ae(ae), .ext_read(ext_read), .ext_write(ext_write),
    .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .ext_ready(ext_ready),
    .region_sel(region_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_region(input logic [31:0] a);
    if (a < LIMIT) return 2'b00;
    for (int i = 0; i < 2; i++)
      if ((a & RMASK[i]) == (RBASE[i] & RMASK[i])) return 2'(1 << i);
    return 2'b00;
  endfunction

  function automatic logic [63:0] all_outs();
    return {ext_ready, ad_oe, ad_out, region_sel, mem_addr, mem_wdata,
            mem_rd, mem_wr, bus_err, addr_err};
  endfunction

  // nph AE-high cycles; slices beyond the second are junk the slave must ignore.
  task automatic send_addr(input logic [31:0] addr, input logic [1:0] sel, input int nph);
    for (int p = 0; p < nph; p++) begin
      ae    = 1'b1;
      ad_in = (p == 0) ? addr[15:0] : (p == 1) ? addr[31:16] : 16'($urandom);
      cyc();
      chk("addr_phase_quiet", {ext_ready, ad_oe, region_sel}, 4'b0);
    end
    ae    = 1'b0;
    ad_in = 16'($urandom);
    cyc();
    if (nph >= 2) begin
      chk("region_sel", region_sel, sel);
      chk("mem_addr", mem_addr, addr);
      chk("addr_err_clear", addr_err, 0);
    end else begin
      chk("addr_err_pulse", addr_err, 1);
      chk("region_sel_malformed", region_sel, 0);
    end
  endtask

  task automatic do_access(input logic [31:0] addr, input bit wr, input bit both,
                           input logic [7:0] wd, input int ack_dly, input logic [7:0] rd,
                           input int nph, input bit fin);
    logic [1:0] sel;
    logic [7:0] exp_d;
    int rdy_at;
    sel = exp_region(addr);
    send_addr(addr, sel, nph);
    ext_read  = !wr || both;
    ext_write = wr || both;
    ad_in     = {8'($urandom), wd};
    cyc();
    if (sel == 2'b00) begin
      repeat (3) begin
        chk("nohit_quiet", {mem_rd, mem_wr, ext_ready, ad_oe, bus_err}, 0);
        cyc();
      end
      ext_read = 0; ext_write = 0;
      cyc();
      return;
    end
    if (both) begin
      chk("conflict_berr", bus_err, 1);
      chk("conflict_noreq", {mem_rd, mem_wr, region_sel}, 0);
      ext_read = 0; ext_write = 0;
      cyc();
      chk("conflict_pulse", {bus_err, mem_rd, mem_wr, ext_ready}, 0);
      return;
    end
    chk("req", {mem_wr, mem_rd}, wr ? 2'b10 : 2'b01);
    if (wr) chk("wdata", mem_wdata, wd);
    if (ack_dly < 0) rdy_at = TIMEOUT;
    else rdy_at = (ack_dly + 1 > MIN_WAIT) ? ack_dly + 1 : MIN_WAIT;
    exp_d = (ack_dly < 0) ? 8'hFF : rd;
    for (int c = 0; c < rdy_at; c++) begin
      mem_ack   = (c == ack_dly);
      mem_rdata = (c == ack_dly) ? rd : 8'($urandom);
      cyc();
      mem_ack = 1'b0;
      chk("ready", ext_ready, 64'(c + 1 == rdy_at));
      chk("bus_err", bus_err, 64'(ack_dly < 0 && c + 1 == rdy_at));
      chk("req_one_cycle", {mem_rd, mem_wr}, 0);
    end
    chk("ad_oe", ad_oe, !wr);
    chk("ad_out", ad_out, wr ? 16'h0 : {8'h00, exp_d});
    chk("sel_held", region_sel, sel);
    if (!fin) return;
    repeat ($urandom_range(0, 2)) begin
      cyc();
      chk("ready_hold", {ext_ready, bus_err}, 2'b10);
    end
    ext_read = 0; ext_write = 0;
    cyc();
    chk("release", {ext_ready, ad_oe, region_sel}, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] edges [4] = '{32'h00001000, 32'h00000FFF, 32'h1A0FFFFF, 32'h1A120000};
    rst = 1'b1; ae = 0; ext_read = 0; ext_write = 0; mem_ack = 0;
    ad_in = '0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    rst = 1'b0;
    cyc();

    do_access(32'h00002000, 0, 0, 8'h00, 3, 8'h5A, 2, 1);
    do_access(32'h1A100004, 1, 0, 8'hC3, 0, 8'h00, 2, 1);
    do_access(32'h00000800, 0, 0, 8'h00, 0, 8'h00, 2, 1);
    do_access(32'h1A110010, 0, 0, 8'h00, -1, 8'h00, 2, 1);

    // Malformed: one AE cycle only.
    send_addr(32'h00003000, 2'b00, 1);
    ext_read = 1;
    cyc();
    chk("malformed_pulse", {addr_err, mem_rd}, 0);
    cyc();
    chk("malformed_noreq", {mem_rd, ext_ready}, 0);
    ext_read = 0;
    cyc();
    do_access(32'h1A105555, 1, 1, 8'h11, 0, 8'h00, 2, 1);
    do_access(32'h1A100100, 0, 0, 8'h00, 1, 8'h3C, 3, 1);

    // Abort during WAIT, then a late ack while the next address is collected.
    send_addr(32'h00004000, 2'b10, 2);
    ext_read = 1;
    cyc();
    chk("abort_req", mem_rd, 1);
    cyc();
    chk("abort_wait_ready", ext_ready, 0);
    ext_read = 0;
    mem_ack = 1; mem_rdata = 8'hEE;
    send_addr(32'h1A10ABCD, 2'b01, 2);
    mem_ack = 0;
    cyc();
    chk("abort_no_ready", {ext_ready, ad_oe, mem_rd}, 0);
    do_access(32'h1A10ABCD, 0, 0, 8'h00, 4, 8'h77, 2, 1);

    // Asynchronous reset while holding DONE.
    do_access(32'h00005000, 0, 0, 8'h00, 2, 8'hA5, 2, 0);
    #2 rst = 1'b1;
    #1 chk("async_reset", all_outs(), 0);
    ext_read = 0;
    #2 rst = 1'b0;
    cyc();
    chk("post_reset", {ext_ready, ad_oe, region_sel}, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: a = {16'h1A10 | 16'($urandom_range(0, 1)), 16'($urandom)};
        1: a = $urandom | 32'h00010000;
        2: a = 32'($urandom_range(0, 32'hFFF));
        default: a = edges[$urandom_range(0, 3)];
      endcase
      do_access(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 8'($urandom),
                $urandom_range(0, 6), 8'($urandom), ($urandom_range(0, 5) == 0) ? 3 : 2, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
